// File: rtl/eeg_band_power_estimator.sv
// Four-band windowed mean-square power estimator. One squarer is shared round-robin, and results leave on a valid/ready stream.
// Optional per-window peak magnitude on pwr_peak when PWR_PEAK_EN is defined.
module eeg_band_power_estimator #(
  parameter int DW       = 10,
  parameter int WIN_LOG2 = 6
) (
  input  logic            clk_fast,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [DW-1:0]   band_in_delta,
  input  logic [DW-1:0]   band_in_theta,
  input  logic [DW-1:0]   band_in_alpha,
  input  logic [DW-1:0]   band_in_beta,
  input  logic            band_avl_delta,
  input  logic            band_avl_theta,
  input  logic            band_avl_alpha,
  input  logic            band_avl_beta,
  output logic [2*DW-2:0] pwr_out,
  output logic [1:0]      pwr_band,
  output logic            pwr_valid,
  input  logic            pwr_ready,
  output logic [3:0]      overrun,
  output logic [DW-2:0]   pwr_peak
);
  localparam int SQW = 2*DW-1;
  localparam int ACW = SQW + WIN_LOG2;
  localparam int PKW = DW-1;

  logic [DW-1:0]       in_w [4];
  logic [3:0]          avl_w;

  logic [DW-1:0]       hold_q [4], hold_d [4];
  logic [3:0]          pend_q, pend_d;
  logic [1:0]          rr_q, rr_d;
  logic [SQW-1:0]      sq_q, sq_d;
  logic                sq_vld_q, sq_vld_d;
  logic [1:0]          tag_q, tag_d;
  logic [ACW-1:0]      acc_q [4], acc_d [4];
  logic [WIN_LOG2-1:0] cnt_q [4], cnt_d [4];
  logic [SQW-1:0]      res_q [4], res_d [4];
  logic [3:0]          res_pend_q, res_pend_d;
  logic [SQW-1:0]      out_q, out_d;
  logic [1:0]          band_q, band_d;
  logic                valid_q, valid_d;
  logic [3:0]          ovr_q, ovr_d;

  logic                gnt_vld, ld_fire, res_busy;
  logic [1:0]          gnt_idx, cand, ld_idx;
  logic signed [2*DW-1:0] gs, prod;
  logic [ACW-1:0]      acc_sum;
  logic [3:0]          eff_pend;

  assign in_w[0] = band_in_delta;
  assign in_w[1] = band_in_theta;
  assign in_w[2] = band_in_alpha;
  assign in_w[3] = band_in_beta;
  assign avl_w   = {band_avl_beta, band_avl_alpha, band_avl_theta, band_avl_delta};

  // A result stays outstanding until handshaken, even once it sits in the output register.
  assign res_busy = res_pend_q[tag_q] | (valid_q & (band_q == tag_q));

  always_comb begin
    hold_d     = hold_q;
    pend_d     = pend_q;
    rr_d       = rr_q;
    sq_d       = sq_q;
    sq_vld_d   = 1'b0;
    tag_d      = tag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    res_pend_d = res_pend_q;
    out_d      = out_q;
    band_d     = band_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    gnt_vld    = 1'b0;
    gnt_idx    = rr_q;
    cand       = rr_q;
    gs         = '0;
    prod       = '0;
    acc_sum    = '0;
    eff_pend   = res_pend_q;
    ld_fire    = 1'b0;
    ld_idx     = '0;

    for (int unsigned i = 0; i < 4; i++) begin
      cand = 2'(rr_q + 2'(i));
      if (!gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) begin
      gs              = {{DW{hold_q[gnt_idx][DW-1]}}, hold_q[gnt_idx]};
      prod            = gs * gs;
      sq_d            = SQW'(prod);
      sq_vld_d        = 1'b1;
      tag_d           = gnt_idx;
      pend_d[gnt_idx] = 1'b0;
      rr_d            = gnt_idx + 2'd1;
    end

    // Pending is judged on the pre-edge state, so a band granted this edge still drops a new strobe.
    for (int unsigned b = 0; b < 4; b++) begin
      if (en && avl_w[b]) begin
        if (pend_q[b]) begin
          ovr_d[b] = 1'b1;
        end else begin
          hold_d[b] = in_w[b];
          pend_d[b] = 1'b1;
        end
      end
    end

    if (sq_vld_q) begin
      cnt_d[tag_q] = cnt_q[tag_q] + 1'b1;
      acc_sum      = acc_q[tag_q] + ACW'(sq_q);
      if (cnt_q[tag_q] == '1) begin
        acc_d[tag_q] = '0;
        if (res_busy) begin
          ovr_d[tag_q] = 1'b1;
        end else begin
          res_d[tag_q]    = SQW'(acc_sum >> WIN_LOG2);
          eff_pend[tag_q] = 1'b1;
        end
      end else begin
        acc_d[tag_q] = acc_sum;
      end
    end

    // A result finishing this edge can go straight to the output register.
    if (!valid_q || pwr_ready) begin
      valid_d = 1'b0;
      for (int unsigned b = 0; b < 4; b++) begin
        if (!ld_fire && eff_pend[b]) begin
          ld_fire = 1'b1;
          ld_idx  = 2'(b);
        end
      end
      if (ld_fire) begin
        valid_d = 1'b1;
        out_d   = res_d[ld_idx];
        band_d  = ld_idx;
      end
    end
    res_pend_d = eff_pend;
    if (ld_fire) res_pend_d[ld_idx] = 1'b0;

    if (clr) begin
      hold_d     = '{default: '0};
      pend_d     = '0;
      rr_d       = '0;
      sq_d       = '0;
      sq_vld_d   = 1'b0;
      tag_d      = '0;
      acc_d      = '{default: '0};
      cnt_d      = '{default: '0};
      res_d      = '{default: '0};
      res_pend_d = '0;
      out_d      = '0;
      band_d     = '0;
      valid_d    = 1'b0;
      ovr_d      = '0;
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      hold_q     <= '{default: '0};
      pend_q     <= '0;
      rr_q       <= '0;
      sq_q       <= '0;
      sq_vld_q   <= 1'b0;
      tag_q      <= '0;
      acc_q      <= '{default: '0};
      cnt_q      <= '{default: '0};
      res_q      <= '{default: '0};
      res_pend_q <= '0;
      out_q      <= '0;
      band_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= '0;
    end else begin
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      sq_q       <= sq_d;
      sq_vld_q   <= sq_vld_d;
      tag_q      <= tag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      res_pend_q <= res_pend_d;
      out_q      <= out_d;
      band_q     <= band_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign pwr_out   = out_q;
  assign pwr_band  = band_q;
  assign pwr_valid = valid_q;
  assign overrun   = ovr_q;

`ifdef PWR_PEAK_EN
  logic [PKW-1:0] mag_q, mag_d, opk_q, opk_d, pk_new;
  logic [PKW-1:0] pk_q [4], pk_d [4], rpk_q [4], rpk_d [4];

  always_comb begin
    mag_d  = mag_q;
    pk_d   = pk_q;
    rpk_d  = rpk_q;
    opk_d  = opk_q;
    pk_new = '0;
    if (gnt_vld) begin
      if (!hold_q[gnt_idx][DW-1])
        mag_d = PKW'(hold_q[gnt_idx]);
      else if (hold_q[gnt_idx] == {1'b1, {(DW-1){1'b0}}})
        mag_d = '1;
      else
        mag_d = PKW'(-hold_q[gnt_idx]);
    end
    if (sq_vld_q) begin
      pk_new = (mag_q > pk_q[tag_q]) ? mag_q : pk_q[tag_q];
      if (cnt_q[tag_q] == '1) begin
        pk_d[tag_q] = '0;
        if (!res_busy) rpk_d[tag_q] = pk_new;
      end else begin
        pk_d[tag_q] = pk_new;
      end
    end
    if (ld_fire) opk_d = rpk_d[ld_idx];
    if (clr) begin
      mag_d = '0;
      pk_d  = '{default: '0};
      rpk_d = '{default: '0};
      opk_d = '0;
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      mag_q <= '0;
      pk_q  <= '{default: '0};
      rpk_q <= '{default: '0};
      opk_q <= '0;
    end else begin
      mag_q <= mag_d;
      pk_q  <= pk_d;
      rpk_q <= rpk_d;
      opk_q <= opk_d;
    end
  end

  assign pwr_peak = opk_q;
`else
  assign pwr_peak = '0;
`endif

endmodule

// File: tb/tb_eeg_band_power_estimator.sv
// Bench for eeg_band_power_estimator (WIN_LOG2=2): directed scenarios plus randomized strobes checked against a per-band window model.
module tb_eeg_band_power_estimator;
  localparam int DW  = 10;
  localparam int WL  = 2;
  localparam int WIN = 4;
`ifdef PWR_PEAK_EN
  localparam bit PK_ON = 1'b1;
`else
  localparam bit PK_ON = 1'b0;
`endif

  logic            clk_fast = 1'b0;
  logic            rst, en, clr, pwr_ready;
  logic [DW-1:0]   bin [4];
  logic [3:0]      bavl;
  logic [2*DW-2:0] pwr_out;
  logic [1:0]      pwr_band;
  logic            pwr_valid;
  logic [3:0]      overrun;
  logic [DW-2:0]   pwr_peak;

  eeg_band_power_estimator #(.DW(DW), .WIN_LOG2(WL)) dut (
    .clk_fast(clk_fast), .rst(rst), .en(en), .clr(clr),
    .band_in_delta(bin[0]), .band_in_theta(bin[1]), .band_in_alpha(bin[2]), .band_in_beta(bin[3]),
    .band_avl_delta(bavl[0]), .band_avl_theta(bavl[1]), .band_avl_alpha(bavl[2]), .band_avl_beta(bavl[3]),
    .pwr_out(pwr_out), .pwr_band(pwr_band), .pwr_valid(pwr_valid), .pwr_ready(pwr_ready),
    .overrun(overrun), .pwr_peak(pwr_peak)
  );

  always #5 clk_fast = ~clk_fast;

  int cyc = 0;
  always @(posedge clk_fast) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Window model: each band collects captured samples; a full window yields mean square and peak.
  typedef struct { int band; int val; int pk; } word_t;
  word_t  expq[$];
  longint m_sum [4];
  int     m_cnt [4];
  int     m_pk  [4];
  logic [3:0] m_ovr;

  function automatic int mag(input int s);
    if (s == -512) return 511;
    return (s < 0) ? -s : s;
  endfunction

  function automatic int find_band(input int b);
    foreach (expq[i]) if (expq[i].band == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    expq.delete();
    for (int b = 0; b < 4; b++) begin m_sum[b] = 0; m_cnt[b] = 0; m_pk[b] = 0; end
    m_ovr = '0;
  endtask

  task automatic model_sample(input int b, input int s);
    word_t w;
    m_sum[b] += longint'(s * s);
    m_cnt[b]++;
    if (mag(s) > m_pk[b]) m_pk[b] = mag(s);
    if (m_cnt[b] == WIN) begin
      if (find_band(b) >= 0) m_ovr[b] = 1'b1;
      else begin
        w.band = b;
        w.val  = int'(m_sum[b] / WIN);
        w.pk   = PK_ON ? m_pk[b] : 0;
        expq.push_back(w);
      end
      m_sum[b] = 0; m_cnt[b] = 0; m_pk[b] = 0;
    end
  endtask

  logic en_n = 1'b1;
  logic rdy_n = 1'b1;

  task automatic drive(input logic [3:0] m, input int v0, input int v1, input int v2, input int v3);
    int v [4];
    v = '{v0, v1, v2, v3};
    @(posedge clk_fast); #1;
    en = en_n;
    pwr_ready = rdy_n;
    bavl = m;
    for (int b = 0; b < 4; b++) begin
      bin[b] = DW'(v[b]);
      if (m[b] && en_n) model_sample(b, v[b]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'h0, 0, 0, 0, 0);
  endtask

  task automatic strobe_n(input int b, input int val, input int n);
    int v [4];
    repeat (n) begin
      v = '{0, 0, 0, 0};
      v[b] = val;
      drive(4'(1 << b), v[0], v[1], v[2], v[3]);
      idle(5);
    end
  endtask

  // Compare process: every handshaken word against the model, plus hold stability under backpressure.
  logic            prev_hold = 1'b0, prev_valid = 1'b0;
  logic [2*DW-2:0] prev_out;
  logic [1:0]      prev_band;
  int first_valid_cyc = -1, nvalid = 0, nwords = 0;
  int last_out = -1, last_band = -1, last_peak = -1;
  int val_log[$], band_log[$];

  always @(negedge clk_fast) begin
    int idx;
    if (rst) begin
      prev_hold = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", pwr_valid, 1);
        chk("hold_out", pwr_out, prev_out);
        chk("hold_band", pwr_band, prev_band);
      end
      if (pwr_valid) begin
        nvalid++;
        if (!prev_valid) first_valid_cyc = cyc;
      end
      if (pwr_valid && pwr_ready) begin
        idx = find_band(int'(pwr_band));
        if (idx < 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word: got band %0d value %0d expected no word", pwr_band, pwr_out);
        end else begin
          chk("word_val", pwr_out, expq[idx].val);
          chk("word_peak", pwr_peak, expq[idx].pk);
          expq.delete(idx);
        end
        last_out = int'(pwr_out); last_band = int'(pwr_band); last_peak = int'(pwr_peak);
        nwords++;
        val_log.push_back(int'(pwr_out));
        band_log.push_back(int'(pwr_band));
      end
      prev_hold  = pwr_valid && !pwr_ready;
      prev_out   = pwr_out;
      prev_band  = pwr_band;
      prev_valid = pwr_valid;
    end
  end

  initial begin
    int s_cyc, w0, since_rdy;
    int nxt [4];
    rst = 1'b1; en = 1'b1; clr = 1'b0; pwr_ready = 1'b1; bavl = '0;
    for (int b = 0; b < 4; b++) bin[b] = '0;
    model_reset();
    repeat (3) @(posedge clk_fast);
    #1;
    chk("rst_out", pwr_out, 0);
    chk("rst_band", pwr_band, 0);
    chk("rst_valid", pwr_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_peak", pwr_peak, 0);
    rst = 1'b0;
    idle(2);

    // delta +4 x4: mean 16, valid 3 cycles after last strobe, one cycle wide
    strobe_n(0, 4, 3);
    nvalid = 0;
    drive(4'b0001, 4, 0, 0, 0);
    s_cyc = cyc;
    idle(8);
    chk("t1_out", last_out, 16);
    chk("t1_band", last_band, 0);
    chk("t1_latency", first_valid_cyc - s_cyc, 3);
    chk("t1_valid_cycles", nvalid, 1);

    // beta -512 x4: full-scale square, no accumulator overflow
    strobe_n(3, -512, 4);
    idle(4);
    chk("t2_out", last_out, 262144);
    chk("t2_band", last_band, 3);
    chk("t2_overrun", overrun, 0);

    // simultaneous strobes on all bands
    val_log.delete(); band_log.delete();
    repeat (4) begin drive(4'hF, 1, -2, 3, -4); idle(5); end
    idle(4);
    chk("t3_count", val_log.size(), 4);
    for (int i = 0; i < val_log.size() && i < 4; i++) begin
      chk("t3_band", band_log[i], i);
      chk("t3_val", val_log[i], (i + 1) * (i + 1));
    end
    chk("t3_overrun", overrun, 0);

    // backpressure across two delta windows: second result dropped
    rdy_n = 1'b0;
    strobe_n(0, 2, 4);
    strobe_n(0, 3, 4);
    idle(4);
    chk("t4_valid", pwr_valid, 1);
    chk("t4_out", pwr_out, 4);
    chk("t4_overrun", overrun, 4'b0001);
    chk("t4_model_ovr", overrun, m_ovr);
    w0 = nwords;
    rdy_n = 1'b1;
    idle(8);
    chk("t4_words", nwords - w0, 1);
    chk("t4_last", last_out, 4);

    // clr mid-window discards the partial window and overrun
    strobe_n(0, 1, 2);
    @(posedge clk_fast); #1; clr = 1'b1; bavl = '0;
    @(posedge clk_fast); #1; clr = 1'b0;
    model_reset();
    chk("t5_overrun_clr", overrun, 0);
    w0 = nwords;
    strobe_n(0, 1, 4);
    idle(4);
    chk("t5_words", nwords - w0, 1);
    chk("t5_out", last_out, 1);
    chk("t5_overrun", overrun, 0);

    // async reset with a word held, then a clean window 5,-7,2,0
    rdy_n = 1'b0;
    strobe_n(0, 5, 1); strobe_n(0, -7, 1); strobe_n(0, 2, 1); strobe_n(0, 0, 1);
    strobe_n(0, 9, 2);
    chk("t6_pre_valid", pwr_valid, 1);
    chk("t6_pre_out", pwr_out, 19);
    chk("t6_pre_peak", pwr_peak, PK_ON ? 7 : 0);
    @(posedge clk_fast); #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_out", pwr_out, 0);
    chk("t6_rst_band", pwr_band, 0);
    chk("t6_rst_valid", pwr_valid, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_peak", pwr_peak, 0);
    @(posedge clk_fast); #1;
    rst = 1'b0;
    model_reset();
    rdy_n = 1'b1;
    strobe_n(0, 5, 1); strobe_n(0, -7, 1); strobe_n(0, 2, 1); strobe_n(0, 0, 1);
    idle(4);
    chk("t6_out", last_out, 19);
    chk("t6_peak", last_peak, PK_ON ? 7 : 0);

    // randomized strobes, en toggling, random backpressure
    for (int b = 0; b < 4; b++) nxt[b] = 0;
    since_rdy = 0;
    for (int t = 0; t < 1500; t++) begin
      logic [3:0] m;
      int v [4];
      if (t % 50 == 0) en_n = ($urandom_range(0, 3) != 0);
      if (since_rdy >= 2) rdy_n = 1'b1;
      else rdy_n = 1'($urandom_range(0, 1));
      since_rdy = rdy_n ? 0 : since_rdy + 1;
      m = '0;
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 7))
          0: v[b] = -512;
          1: v[b] = 511;
          default: v[b] = int'($urandom_range(0, 1023)) - 512;
        endcase
        if (t >= nxt[b] && $urandom_range(0, 3) == 0) begin
          m[b] = 1'b1;
          nxt[b] = t + 6;
        end
      end
      drive(m, v[0], v[1], v[2], v[3]);
    end
    en_n = 1'b1;
    rdy_n = 1'b1;
    idle(30);
    chk("rand_drained", expq.size(), 0);
    chk("rand_overrun", overrun, m_ovr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
